// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the ID/EX/MEM pipeline registers and the hazard/redirect controller.
// The master side is the pipeline; the slave side is the controller that drives the fetch controls.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             hold_req;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             id_is_branch;
    logic             id_br_eq;
    logic             id_is_jump;
    logic [31:0]      id_br_target;
    logic [31:0]      id_j_target;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [4:0]       ex_dst;
    logic             mem_mem_read;
    logic [4:0]       mem_dst;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             redirect;
    logic [31:0]      redirect_pc;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output hold_req, id_rs, id_rt, id_uses_rt, id_is_branch, id_br_eq, id_is_jump,
               id_br_target, id_j_target, ex_mem_read, ex_reg_write, ex_dst,
               mem_mem_read, mem_dst,
        input  pc_write, if_id_write, if_id_flush, id_ex_flush, redirect, redirect_pc,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  hold_req, id_rs, id_rt, id_uses_rt, id_is_branch, id_br_eq, id_is_jump,
               id_br_target, id_j_target, ex_mem_read, ex_reg_write, ex_dst,
               mem_mem_read, mem_dst,
        output pc_write, if_id_write, if_id_flush, id_ex_flush, redirect, redirect_pc,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and redirect controller: inserts load-use / branch-operand bubbles and resolves
// beq/j in ID, driving the IFU PC-update and pipeline-register write/flush controls.
module pipe_hazard_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 16
) (
    input logic              clk,
    input logic              reset,
    pipe_hazard_ctrl_if.slave bus
);

    typedef enum logic {
        ST_RUN,
        ST_STALL
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       stall_left_q;
    logic [1:0]       stall_left_d;
    logic [31:0]      redirect_pc_q;
    logic [31:0]      redirect_pc_d;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic             ex_hit;
    logic             mem_hit;
    logic             haz_lu;
    logic             haz_ba;
    logic             haz_bl2;
    logic             haz_bl1;
    logic             haz_two;
    logic             haz_any;
    logic             take_redirect;
    logic [31:0]      redirect_target;
    logic             bubble;
    logic             redirect_fire;

    // Register 0 is hard-wired, so a destination of 0 can never create a dependency.
    function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic uses_rt);
        return (dst != 5'd0) && ((dst == rs) || (uses_rt && (dst == rt)));
    endfunction

    assign ex_hit  = reg_match(bus.ex_dst, bus.id_rs, bus.id_rt, bus.id_uses_rt);
    assign mem_hit = reg_match(bus.mem_dst, bus.id_rs, bus.id_rt, bus.id_uses_rt);

    assign haz_lu  = bus.ex_mem_read && ex_hit;
    assign haz_ba  = bus.id_is_branch && bus.ex_reg_write && !bus.ex_mem_read && ex_hit;
    assign haz_bl2 = bus.id_is_branch && bus.ex_mem_read && ex_hit;
    assign haz_bl1 = bus.id_is_branch && bus.mem_mem_read && mem_hit;
    assign haz_two = haz_bl2;
    assign haz_any = haz_lu || haz_ba || haz_bl2 || haz_bl1;

    assign take_redirect   = bus.id_is_jump || (bus.id_is_branch && bus.id_br_eq);
    assign redirect_target = bus.id_is_jump ? bus.id_j_target : bus.id_br_target;

    always_comb begin
        state_d         = state_q;
        stall_left_d    = stall_left_q;
        redirect_pc_d   = redirect_pc_q;
        bubble          = 1'b0;
        redirect_fire   = 1'b0;
        bus.pc_write    = 1'b1;
        bus.if_id_write = 1'b1;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        bus.redirect    = 1'b0;

        if (!reset) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.if_id_flush = 1'b1;
            bus.id_ex_flush = 1'b1;
        end else if (bus.hold_req) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
        end else if (state_q == ST_STALL) begin
            bubble          = 1'b1;
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.id_ex_flush = 1'b1;
            if (stall_left_q <= 2'd1) begin
                state_d      = ST_RUN;
                stall_left_d = 2'd0;
            end else begin
                stall_left_d = stall_left_q - 2'd1;
            end
        end else if (haz_any) begin
            // A two-bubble hazard issues the first bubble now and parks the second in STALL.
            bubble          = 1'b1;
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
            bus.id_ex_flush = 1'b1;
            if (haz_two) begin
                state_d      = ST_STALL;
                stall_left_d = 2'd1;
            end
        end else if (take_redirect) begin
            redirect_fire   = 1'b1;
            bus.redirect    = 1'b1;
            bus.if_id_flush = 1'b1;
            redirect_pc_d   = redirect_target;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_RUN;
            stall_left_q  <= 2'd0;
            redirect_pc_q <= RESET_PC;
            stall_cnt_q   <= '0;
            flush_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            stall_left_q  <= stall_left_d;
            redirect_pc_q <= redirect_pc_d;
            if (bubble && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            end
            if (redirect_fire && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            end
        end
    end

    // The target is visible in the redirect cycle itself, then held by the register.
    assign bus.redirect_pc = redirect_fire ? redirect_target : redirect_pc_q;
    assign bus.stall_cnt   = stall_cnt_q;
    assign bus.flush_cnt   = flush_cnt_q;

endmodule
